// File: rtl/gigex_cmd_rx.sv
// GigEx Rx byte channel to 32-bit command word stream, buffered in an FWFT word FIFO.
// Optional partial-word idle timeout: define GIGEX_CMD_RX_TIMEOUT_EN.
module gigex_cmd_rx #(
  parameter int unsigned CHANNEL        = 0,
  parameter int unsigned CMD_LEN        = 32,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           q,
  input  logic                 n_rx,
  input  logic [2:0]           rc,
  output logic [7:0]           n_rf,
  output logic [CMD_LEN-1:0]   cmd_data,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [CNT_WIDTH-1:0] overflow_cnt,
  output logic [CNT_WIDTH-1:0] frame_err_cnt
);

  localparam int unsigned Bytes = CMD_LEN / 8;
  localparam int unsigned BcntW = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW  = PtrW + 1;

  if (TIMEOUT_CYCLES == 0 || FIFO_DEPTH < 4 || CMD_LEN % 8 != 0 || CHANNEL > 7) begin : g_bad_cfg
    $error("gigex_cmd_rx: illegal parameter combination");
  end

  logic [BcntW-1:0]     bcnt_q, bcnt_d, bcnt_eff;
  logic [CMD_LEN-1:0]   asm_q, asm_d, word;
  logic [CMD_LEN-1:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0]      occ_q, occ_d;
  logic [CNT_WIDTH-1:0] ovf_q, ovf_d, ferr_q, ferr_d;
  logic [7:0]           n_rf_q, n_rf_d;
  logic                 accept, stray, expire, complete, push, pop, full, ferr_inc;

  assign accept    = !n_rx && (rc == 3'(CHANNEL));
  assign stray     = !n_rx && (rc != 3'(CHANNEL));
  assign full      = (occ_q == OccW'(FIFO_DEPTH));
  assign cmd_valid = (occ_q != '0);
  assign pop       = cmd_valid && cmd_ready;
  assign word      = (asm_q << 8) | CMD_LEN'(q);

`ifdef GIGEX_CMD_RX_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IdleW-1:0] idle_q, idle_d;

  // Expiry edge: TIMEOUT_CYCLES edges since the last accepted byte of a partial word.
  assign expire = (bcnt_q != '0) && (idle_q == IdleW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    idle_d = idle_q + IdleW'(1);
    if (accept || expire || bcnt_q == '0) idle_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle_q <= '0;
    else      idle_q <= idle_d;
  end
`else
  assign expire = 1'b0;
`endif

  // An expiring partial word is gone before this edge's byte is considered.
  assign bcnt_eff = expire ? '0 : bcnt_q;
  assign complete = accept && (bcnt_eff == BcntW'(Bytes - 1));
  assign push     = complete && (!full || pop);

  always_comb begin
    bcnt_d   = bcnt_eff;
    asm_d    = asm_q;
    ovf_d    = ovf_q;
    ferr_d   = ferr_q;
    ferr_inc = expire;
    if (accept) begin
      asm_d  = word;
      bcnt_d = complete ? '0 : bcnt_eff + BcntW'(1);
    end else if (stray && bcnt_eff != '0) begin
      bcnt_d   = '0;
      ferr_inc = 1'b1;
    end
    if (ferr_inc && ferr_q != '1) ferr_d = ferr_q + CNT_WIDTH'(1);
    if (complete && !push && ovf_q != '1) ovf_d = ovf_q + CNT_WIDTH'(1);

    occ_d = occ_q + OccW'(push) - OccW'(pop);
    // One spare slot absorbs the bytes GigEx may still send after the flag falls.
    n_rf_d          = '0;
    n_rf_d[CHANNEL] = (occ_d < OccW'(FIFO_DEPTH - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_q   <= '0;
      asm_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= '0;
      ferr_q   <= '0;
      n_rf_q   <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      asm_q  <= asm_d;
      occ_q  <= occ_d;
      ovf_q  <= ovf_d;
      ferr_q <= ferr_d;
      n_rf_q <= n_rf_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word;
  end

  assign cmd_data      = cmd_valid ? mem_q[rd_ptr_q] : '0;
  assign n_rf          = n_rf_q;
  assign overflow_cnt  = ovf_q;
  assign frame_err_cnt = ferr_q;

endmodule

// File: tb/tb_gigex_cmd_rx.sv
// Randomized scoreboard bench for gigex_cmd_rx against a byte/word queue model.
module tb_gigex_cmd_rx;

  localparam int unsigned CHANNEL = 0;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TO      = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  q = '0;
  logic        n_rx = 1'b1;
  logic [2:0]  rc = '0;
  logic [7:0]  n_rf;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [15:0] overflow_cnt, frame_err_cnt;

  int checks = 0;
  int errors = 0;

  // Model: bytes of the word in progress, words expected out, FIFO occupancy.
  logic [7:0]  partial[$];
  logic [31:0] exp_q[$];
  int          occ = 0;
  int          idle = 0;
  int          m_ovf = 0;
  int          m_ferr = 0;

  gigex_cmd_rx #(
    .CHANNEL(CHANNEL), .CMD_LEN(32), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(16), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .q(q), .n_rx(n_rx), .rc(rc), .n_rf(n_rf),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .overflow_cnt(overflow_cnt), .frame_err_cnt(frame_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a word leaves on the coming edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (rst && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h, expected none", cmd_data);
      end else begin
        check("word_data", cmd_data, exp_q.pop_front());
      end
    end
  end

  function automatic logic [7:0] exp_nrf();
    logic [7:0] e;
    e = '0;
    e[CHANNEL] = (occ < int'(DEPTH) - 1);
    return e;
  endfunction

  task automatic step(input bit v, input logic [7:0] b, input logic [2:0] ch, input bit rdy);
    bit pop;
    n_rx      = !v;
    q         = b;
    rc        = ch;
    cmd_ready = rdy;
    pop = (occ > 0) && rdy;
`ifdef GIGEX_CMD_RX_TIMEOUT_EN
    if (partial.size() > 0 && idle == int'(TO) - 1) begin
      partial.delete();
      m_ferr++;
    end
`endif
    if (v && ch == 3'(CHANNEL)) begin
      partial.push_back(b);
      idle = 0;
      if (partial.size() == 4) begin
        if (occ < int'(DEPTH) || pop) begin
          exp_q.push_back({partial[0], partial[1], partial[2], partial[3]});
          occ++;
        end else begin
          m_ovf++;
        end
        partial.delete();
      end
    end else if (v) begin
      if (partial.size() > 0) m_ferr++;
      partial.delete();
    end else if (partial.size() > 0) begin
      idle++;
    end
    if (pop) occ--;
    @(posedge clk);
    #1;
    check("cmd_valid", cmd_valid, (occ > 0));
    check("n_rf", n_rf, exp_nrf());
  endtask

  task automatic idle_steps(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 3'(CHANNEL), rdy);
  endtask

  task automatic send_word(input logic [31:0] w, input bit rdy);
    for (int i = 0; i < 4; i++) step(1'b1, w[31-8*i -: 8], 3'(CHANNEL), rdy);
  endtask

  task automatic check_cnts();
    check("overflow_cnt", overflow_cnt, 64'(m_ovf));
    check("frame_err_cnt", frame_err_cnt, 64'(m_ferr));
  endtask

  task automatic check_reset_state();
    check("rst_n_rf", n_rf, 8'h00);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_cmd_data", cmd_data, 32'h0);
    check("rst_overflow_cnt", overflow_cnt, 16'h0);
    check("rst_frame_err_cnt", frame_err_cnt, 16'h0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    check_reset_state();
    partial.delete();
    exp_q.delete();
    occ = 0; idle = 0; m_ovf = 0; m_ferr = 0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    bit          v, rdy;
    logic [2:0]  ch;

    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b1;

    // First word, held until ready.
    send_word(32'hDEADBEEF, 1'b0);
    check("first_word_data", cmd_data, 32'hDEADBEEF);
    check("first_word_nrf", n_rf, 8'h01);
    idle_steps(2, 1'b1);

    // Fill to full with ready low; 17th word must be dropped.
    for (int i = 1; i <= 17; i++) begin
      send_word($urandom, 1'b0);
      if (i == 15) check("nrf_low_at_15", n_rf[CHANNEL], 1'b0);
    end
    check("overflow_after_17", overflow_cnt, 16'd1);
    idle_steps(DEPTH + 2, 1'b1);

    // Stray byte in mid-word.
    step(1'b1, 8'h55, 3'(CHANNEL), 1'b1);
    step(1'b1, 8'h66, 3'(CHANNEL), 1'b1);
    step(1'b1, 8'h77, 3'(CHANNEL + 1), 1'b1);
    send_word(32'h01020304, 1'b1);
    check("frame_err_after_stray", frame_err_cnt, 16'd1);
    idle_steps(2, 1'b1);

    // Back-to-back words at full throughput.
    for (int i = 0; i < 50; i++) send_word($urandom, 1'b1);
    idle_steps(2, 1'b1);
    check_cnts();

    // Reset mid-word.
    step(1'b1, 8'hA1, 3'(CHANNEL), 1'b0);
    step(1'b1, 8'hA2, 3'(CHANNEL), 1'b0);
    pulse_reset();
    send_word(32'h11223344, 1'b1);
    idle_steps(2, 1'b1);
    check_cnts();

    // Partial word followed by a long idle gap.
    step(1'b1, 8'h10, 3'(CHANNEL), 1'b1);
    step(1'b1, 8'h20, 3'(CHANNEL), 1'b1);
    step(1'b1, 8'h30, 3'(CHANNEL), 1'b1);
    idle_steps(TO, 1'b1);
    send_word(32'hAABBCCDD, 1'b1);
    idle_steps(2, 1'b1);
`ifdef GIGEX_CMD_RX_TIMEOUT_EN
    check("timeout_frame_err", frame_err_cnt, 16'd1);
`else
    check("no_timeout_frame_err", frame_err_cnt, 16'd0);
`endif
    check_cnts();

    // Random traffic with alternating drain/backpressure phases.
    for (int i = 0; i < 2400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      ch  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'(CHANNEL);
      rdy = ((i / 300) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
      step(v, 8'($urandom), ch, rdy);
      if (i % 200 == 199) check_cnts();
    end
    idle_steps(DEPTH + 4, 1'b1);
    check_cnts();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gigex_cmd_rx.md
Name: gigex_cmd_rx

Overview:
- Receive side of the GigEx byte interface (Q/nRx/RC/nRF), sys_clk domain.
- Accepts bytes on one GigEx Rx channel and packs them MSB-first into 32-bit command words; byte order matches the MSB-first ordering of the Tx path.
- Buffers words in an internal FWFT FIFO and presents them as a valid/ready stream toward the microblaze command path.
- Drives the active-low per-channel Rx-full flags, with slack for bytes already in flight.

Parameters:
CHANNEL, 0, GigEx Rx channel accepted (0-7)
CMD_LEN, 32, command word width; multiple of 8; BYTES = CMD_LEN/8
FIFO_DEPTH, 16, word FIFO depth; power of 2, >= 4
CNT_WIDTH, 16, width of error counters
TIMEOUT_CYCLES, 1024, partial-word timeout (used only with the optional feature)

Ports:
clk  in  1  system clock (sys_clk)
rst  in  1  asynchronous, active-low reset
q  in  8  Rx byte from GigEx
n_rx  in  1  Rx byte valid, active-low
rc  in  3  Rx byte channel
n_rf  out  8  Rx FIFO full per channel, active-low (0 = full)
cmd_data  out  CMD_LEN  command word, first received byte in [CMD_LEN-1 -: 8]
cmd_valid  out  1  word available
cmd_ready  in  1  consumer accepts the word
overflow_cnt  out  CNT_WIDTH  words dropped because the FIFO was full
frame_err_cnt  out  CNT_WIDTH  partial words discarded

Behaviour:
- Reset (rst = 0, asynchronous): n_rf = 8'h00, cmd_valid = 0, cmd_data = 0, FIFO empty, byte counter = 0, both counters = 0.
- Byte accept: at a posedge with n_rx = 0 and rc == CHANNEL, q is shifted into the assembly register and the byte counter increments.
- Word complete: on the BYTES-th byte the word {b0,b1,...} is written to the FIFO on that same edge and the byte counter returns to 0.
  - If the FIFO was empty, cmd_valid = 1 in the following cycle (1-cycle latency from the last byte edge).
- FIFO handshake:
  - FWFT: cmd_data is valid whenever cmd_valid = 1.
  - A pop occurs on an edge with cmd_valid & cmd_ready.
  - cmd_data and cmd_valid are held stable while cmd_ready = 0.
  - A simultaneous push and pop leaves occupancy unchanged; full throughput is supported.
- FIFO full when a word completes: the word is dropped, overflow_cnt increments (saturating), and the FIFO contents are untouched. A simultaneous pop frees a slot, so the word is NOT dropped in that case.
- n_rf (registered):
  - Bit CHANNEL = 0 when occupancy >= FIFO_DEPTH-1, else 1. The single free word slot absorbs the up to 2 bytes GigEx may still send after the flag falls.
  - All other bits are held at 0 (full), so unused channels are blocked.
- Stray byte (n_rx = 0, rc != CHANNEL): the byte is ignored. If the byte counter != 0, the partial word is discarded, the counter is cleared, and frame_err_cnt increments (saturating).
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-word or with a non-empty FIFO: all state is cleared immediately; the partial word and queued words are lost.

Optional Feature:
- Macro: GIGEX_CMD_RX_TIMEOUT_EN.
- Defined: an idle counter starts at each accepted byte while the byte counter != 0. When TIMEOUT_CYCLES cycles pass with no accepted byte:
  - the partial word is discarded, the byte counter is cleared, and frame_err_cnt increments;
  - a byte arriving on the expiry edge is treated as byte 0 of a new word.
- Not defined: there is no idle counter, and a partial word is held indefinitely until completed or a stray byte arrives.

Test Plan:
- Reset release, bytes 0xDE,0xAD,0xBE,0xEF on rc = CHANNEL back-to-back -> cmd_valid = 1 one cycle after the 4th byte, cmd_data = 32'hDEADBEEF; n_rf = 8'h01 for CHANNEL = 0.
- cmd_ready = 0, 15 words sent -> n_rf[CHANNEL] = 0 after the 15th word. 16th word accepted. 17th word dropped, overflow_cnt = 1. Drain yields words 1-16 in order.
- 2 bytes on CHANNEL, then 1 byte on rc = CHANNEL+1, then 0x01,0x02,0x03,0x04 -> frame_err_cnt = 1, output 32'h01020304.
- Continuous 4-byte words with cmd_ready = 1 every cycle -> no drops, n_rf[CHANNEL] stays 1, output sequence matches input.
- rst pulsed low after 2 bytes of a word, then a full word 0x11223344 -> only 32'h11223344 is delivered; counters = 0.
- With GIGEX_CMD_RX_TIMEOUT_EN, TIMEOUT_CYCLES = 8: 3 bytes, 8 idle cycles, then 0xAA,0xBB,0xCC,0xDD -> frame_err_cnt = 1, output 32'hAABBCCDD. Without the macro: the same stimulus yields a single word built from the 3 old bytes plus 0xAA, and frame_err_cnt = 0.
